// File: rtl/hazard_unit.sv
// Hazard/forwarding unit for the 5-stage core: operand forwarding, stall/flush generation,
// a debug halt/drain handshake and saturating load-stall / branch-flush counters.
module hazard_unit #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             halt_req,
  input  logic             cnt_clr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             halt_ack,
  output logic [CNT_W-1:0] ldstall_cnt,
  output logic [CNT_W-1:0] brflush_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           r_state;
  logic [DW-1:0]    r_drain;
  logic             r_halt_ack;
  logic [CNT_W-1:0] r_ldstall_cnt;
  logic [CNT_W-1:0] r_brflush_cnt;

  logic w_ldrstall;
  logic w_pcwrpend;
  logic w_redirect;
  logic w_any_pcsrc;

  // Memory-stage result wins over writeback because it is the younger write.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic [3:0] wa_m,
                                         input logic wr_m, input logic [3:0] wa_w,
                                         input logic wr_w);
    logic [1:0] sel;
    if (wr_m && (ra == wa_m)) begin
      sel = 2'b10;
    end else if (wr_w && (ra == wa_w)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign w_ldrstall  = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign w_pcwrpend  = PCSrcD | PCSrcE | PCSrcM;
  assign w_redirect  = BranchTakenE | PCSrcW;
  assign w_any_pcsrc = w_pcwrpend | PCSrcW;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    if (!reset) begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
    end else begin
      ForwardAE = fwd_sel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
      ForwardBE = fwd_sel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
      StallD    = w_ldrstall;
      StallF    = w_ldrstall | w_pcwrpend;
      FlushE    = w_ldrstall | BranchTakenE;
      FlushD    = w_pcwrpend | PCSrcW | BranchTakenE;
      case (r_state)
        S_RUN: begin
          FlushD = w_pcwrpend | PCSrcW | BranchTakenE;
        end
        // A redirect must still let the PC load its target while draining.
        S_DRAIN: begin
          FlushD = 1'b1;
          if (!w_redirect) begin
            StallF = 1'b1;
          end else begin
            StallF = w_ldrstall | w_pcwrpend;
          end
        end
        S_HALTED: begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushD = 1'b1;
        end
        default: begin
          FlushD = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_drain    <= '0;
      r_halt_ack <= 1'b0;
    end else begin
      r_halt_ack <= (r_state == S_HALTED) && halt_req;
      case (r_state)
        S_RUN: begin
          r_drain <= '0;
          if (halt_req) begin
            r_state <= S_DRAIN;
          end else begin
            r_state <= S_RUN;
          end
        end
        // Abort beats completion; any PC activity restarts the drain window.
        S_DRAIN: begin
          if (!halt_req) begin
            r_state <= S_RUN;
            r_drain <= '0;
          end else if ((r_drain == DRAIN_LAST) && !w_any_pcsrc && !BranchTakenE) begin
            r_state <= S_HALTED;
            r_drain <= '0;
          end else if (w_redirect || w_pcwrpend) begin
            r_drain <= '0;
          end else if (r_drain != DRAIN_LAST) begin
            r_drain <= r_drain + DW'(1);
          end else begin
            r_drain <= r_drain;
          end
        end
        S_HALTED: begin
          r_drain <= '0;
          if (!halt_req) begin
            r_state <= S_RUN;
          end else begin
            r_state <= S_HALTED;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_drain <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || cnt_clr) begin
      r_ldstall_cnt <= '0;
      r_brflush_cnt <= '0;
    end else begin
      if (w_ldrstall && (r_ldstall_cnt != {CNT_W{1'b1}})) begin
        r_ldstall_cnt <= r_ldstall_cnt + CNT_W'(1);
      end else begin
        r_ldstall_cnt <= r_ldstall_cnt;
      end
      if (BranchTakenE && (r_brflush_cnt != {CNT_W{1'b1}})) begin
        r_brflush_cnt <= r_brflush_cnt + CNT_W'(1);
      end else begin
        r_brflush_cnt <= r_brflush_cnt;
      end
    end
  end

  assign halt_ack    = r_halt_ack;
  assign ldstall_cnt = r_ldstall_cnt;
  assign brflush_cnt = r_brflush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, stalls/flushes, halt/drain handshake, counters.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteM, RegWriteW, MemtoRegE;
  logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic        halt_req, cnt_clr;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE, halt_ack;
  logic [15:0] ldstall_cnt, brflush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_unit #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .halt_req(halt_req), .cnt_clr(cnt_clr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .halt_ack(halt_ack), .ldstall_cnt(ldstall_cnt), .brflush_cnt(brflush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
    BranchTakenE = 1'b0; halt_req = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    // Reset overrides outputs combinationally even with a matching forward.
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1;
    #1;
    check_eq("rst_fwdA", 32'(ForwardAE), 32'd0);
    check_eq("rst_flushD", 32'(FlushD), 32'd1);
    check_eq("rst_flushE", 32'(FlushE), 32'd1);
    check_eq("rst_stallF", 32'(StallF), 32'd0);
    tick(); tick();
    check_eq("rst_ack", 32'(halt_ack), 32'd0);
    check_eq("rst_ldcnt", 32'(ldstall_cnt), 32'd0);
    check_eq("rst_brcnt", 32'(brflush_cnt), 32'd0);
    idle_inputs();
    reset = 1'b1;
    #1;
    check_eq("run_flushD", 32'(FlushD), 32'd0);
    check_eq("run_flushE", 32'(FlushE), 32'd0);

    // Forwarding priority
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
    #1;
    check_eq("fwdA_M", 32'(ForwardAE), 32'd2);
    check_eq("fwdB_none", 32'(ForwardBE), 32'd0);
    RegWriteM = 1'b0;
    #1;
    check_eq("fwdA_W", 32'(ForwardAE), 32'd1);
    RA2E = 4'd3; RegWriteM = 1'b1; WA3M = 4'd7;
    #1;
    check_eq("fwdB_W", 32'(ForwardBE), 32'd1);
    RA2E = 4'd7;
    #1;
    check_eq("fwdB_M", 32'(ForwardBE), 32'd2);
    RegWriteW = 1'b0; RegWriteM = 1'b0;
    #1;
    check_eq("fwdA_off", 32'(ForwardAE), 32'd0);
    idle_inputs();

    // Load-use stall
    MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
    #1;
    check_eq("ld_stallF", 32'(StallF), 32'd1);
    check_eq("ld_stallD", 32'(StallD), 32'd1);
    check_eq("ld_flushE", 32'(FlushE), 32'd1);
    check_eq("ld_flushD", 32'(FlushD), 32'd0);
    tick();
    idle_inputs();
    #1;
    check_eq("ld_cnt1", 32'(ldstall_cnt), 32'd1);
    check_eq("ld_clear", 32'(StallD), 32'd0);
    tick();
    check_eq("ld_cnt_hold", 32'(ldstall_cnt), 32'd1);

    // Taken branch
    BranchTakenE = 1'b1;
    #1;
    check_eq("br_flushD", 32'(FlushD), 32'd1);
    check_eq("br_flushE", 32'(FlushE), 32'd1);
    check_eq("br_stallF", 32'(StallF), 32'd0);
    tick();
    BranchTakenE = 1'b0;
    #1;
    check_eq("br_cnt1", 32'(brflush_cnt), 32'd1);

    // PC write travelling D..W
    for (int i = 0; i < 4; i++) begin
      PCSrcD = (i == 0); PCSrcE = (i == 1); PCSrcM = (i == 2); PCSrcW = (i == 3);
      #1;
      check_eq($sformatf("pc_stallF%0d", i), 32'(StallF), (i < 3) ? 32'd1 : 32'd0);
      check_eq($sformatf("pc_flushD%0d", i), 32'(FlushD), 32'd1);
      tick();
    end
    idle_inputs();
    #1;
    check_eq("pc_done", 32'(FlushD), 32'd0);

    // Halt on idle pipe: ack after the 6th edge
    halt_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        check_eq("drn_flushD", 32'(FlushD), 32'd1);
        check_eq("drn_stallF", 32'(StallF), 32'd1);
        check_eq("drn_stallD", 32'(StallD), 32'd0);
      end
      if (k == 5) check_eq("halt_ack5", 32'(halt_ack), 32'd0);
    end
    check_eq("halt_ack6", 32'(halt_ack), 32'd1);
    check_eq("hlt_stallD", 32'(StallD), 32'd1);
    halt_req = 1'b0;
    tick();
    check_eq("ack_drop", 32'(halt_ack), 32'd0);
    check_eq("back_run", 32'(StallF), 32'd0);

    // Redirect mid-drain releases StallF and restarts the window
    halt_req = 1'b1;
    tick(); tick(); tick();
    BranchTakenE = 1'b1;
    #1;
    check_eq("drn_redir_stallF", 32'(StallF), 32'd0);
    check_eq("drn_redir_flushD", 32'(FlushD), 32'd1);
    tick();
    BranchTakenE = 1'b0;
    for (int k = 5; k <= 8; k++) tick();
    check_eq("restart_ack8", 32'(halt_ack), 32'd0);
    tick();
    check_eq("restart_ack9", 32'(halt_ack), 32'd1);
    check_eq("br_cnt2", 32'(brflush_cnt), 32'd2);

    // Reset while halted returns to RUN and clears counters
    reset = 1'b0;
    tick();
    check_eq("rst_hlt_ack", 32'(halt_ack), 32'd0);
    check_eq("rst_hlt_cnt", 32'(brflush_cnt), 32'd0);
    halt_req = 1'b0;
    reset = 1'b1;
    tick();
    check_eq("rst_hlt_run", 32'(StallD), 32'd0);
    check_eq("rst_hlt_ack2", 32'(halt_ack), 32'd0);

    // Saturation then clear
    MemtoRegE = 1'b1; WA3E = 4'd5; RA1D = 4'd5;
    repeat (65535) @(posedge clk);
    #1;
    check_eq("sat_ffff", 32'(ldstall_cnt), 32'h0000FFFF);
    tick();
    check_eq("sat_hold", 32'(ldstall_cnt), 32'h0000FFFF);
    cnt_clr = 1'b1;
    tick();
    check_eq("clr_beats_inc", 32'(ldstall_cnt), 32'd0);
    idle_inputs();
    tick();
    check_eq("clr_stay", 32'(ldstall_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
